ppu_vram_ctrl: RTL and testbench
================================

// Module: ppu_vram_ctrl
// PURPOSE
//  Parametrised two-port PPU VRAM controller; next generation of the PPU memory controller.
//  Arbitrates renderer fetches against CPU-side PPUDATA accesses onto pattern, name-table and palette storage.
//  Applies cartridge-selected name-table mirroring and NES palette aliasing.
//  Returns registered read data with a valid strobe.
// PARAMETERS
//  NT_ADDR_W    11  name-table RAM address width; 11 = 2 KB, 12 = 4 KB (enables four-screen)
//  PT_WRITABLE  1   1 = pattern table is CHR-RAM (writable); 0 = CHR-ROM, writes dropped but acked
//  STARVE_MAX   4   consecutive CPU-losing cycles before CPU is forced to win (range 1..15)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous, active-low reset
//  mirror_mode  in   3   0 horiz, 1 vert, 2 single-A, 3 single-B, 4 four-screen; sampled at grant
//  rnd_req      in   1   renderer read request; held until rnd_ack
//  rnd_addr     in   14  renderer address
//  rnd_ack      out  1   request accepted this cycle
//  rnd_rvalid   out  1   rnd_rdata valid (1 cycle after ack)
//  rnd_rdata    out  8   renderer read data
//  cpu_req      in   1   CPU-side request; held until cpu_ack
//  cpu_wr       in   1   1 = write, 0 = read
//  cpu_addr     in   14  CPU-side address
//  cpu_wdata    in   8   write data
//  cpu_ack      out  1   request accepted this cycle
//  cpu_rvalid   out  1   cpu_rdata valid (1 cycle after read ack)
//  cpu_rdata    out  8   CPU read data
// BEHAVIOUR
//  Reset: all acks/rvalids 0, rdata 8'h00, starve counter 0, pending read cleared, palette regs 0.
//   BRAM contents are not reset.
//  Grant: at most one port per cycle.
//   Renderer wins ties unless starve_cnt == STARVE_MAX, in which case the CPU wins.
//   ack is combinational in the grant cycle.
//  starve_cnt: +1 when cpu_req is high and the CPU is not granted; cleared on CPU grant or when cpu_req is low.
//   Saturates at STARVE_MAX.
//  Decode (grant cycle): addr[13]=0 -> pattern (addr[12:0]).
//   addr[13:8]=6'h3F -> palette.
//   Otherwise -> name table.
//  NT map from a10 = addr[10], a11 = addr[11]:
//   horiz -> {a11, addr[9:0]}.
//   vert -> {a10, addr[9:0]}.
//   single-A -> {0, addr[9:0]}.
//   single-B -> {1, addr[9:0]}.
//   four-screen -> {a11, a10, addr[9:0]} if NT_ADDR_W=12; else treated as vert.
//   Upper unused bits are 0.
//  Palette: 32 x 6-bit registers, index addr[4:0] with bit4 forced 0 when addr[1:0]==0 (3F10/14/18/1C alias).
//   Reads return {2'b00, pal}; writes store wdata[5:0].
//  Read latency: exactly 1 cycle ack->rvalid for all regions.
//   A palette read is registered to match BRAM latency.
//   rvalid is a 1-cycle pulse; rdata holds its last value otherwise.
//  Writes: committed on the ack edge; no rvalid.
//   Pattern writes with PT_WRITABLE=0 are acked and discarded.
//  Back-to-back: a new grant is allowed every cycle; the read pipeline register tags port + source.
//  Reset mid-read: a pending rvalid is suppressed; no rvalid follows reset release.
//  mirror_mode change while a read is in flight affects only later grants.
// STRUCTURE
//  Shared package ppu_pkg: MIRROR_* encodings, PPU_PAL_BASE=6'h3F, region enum {RGN_PT, RGN_NT, RGN_PAL}.
//  Sub-module ppu_vram_arb: grant logic, starve counter, ack generation.
//  BRAMs: single_port_ram_sync instances (pattern 13-bit, name table NT_ADDR_W).
// TESTING
//  1 Reset, then CPU writes 8'hA5 @0x2005 in vert mode; read 0x2805.
//    -> cpu_rvalid 1 cycle after ack, rdata 8'hA5.
//    Same sequence in horiz mode: 0x2405 returns 8'hA5.
//  2 CPU writes 8'h3F to 0x3F10; reads 0x3F00 -> 8'h3F.
//    Write 8'hFF @0x3F01; read -> 8'h3F (6-bit).
//  3 rnd_req held high every cycle, cpu_req high, STARVE_MAX=4.
//    -> CPU acked on the 5th cycle, then renderer resumes.
//  4 Back-to-back renderer reads 0x0000, 0x2000, 0x3F00 on consecutive cycles.
//    -> three rvalid pulses, each 1 cycle after its ack, data in order.
//  5 PT_WRITABLE=0: write 8'h12 @0x0100 -> acked; read returns the prior content.
//    Four-screen with NT_ADDR_W=11: behaves as vert.
//  6 Assert rst_n low the cycle after a read ack -> no rvalid; all outputs 0 while low.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared PPU VRAM definitions: mirroring encodings, region decode, address helpers.
package ppu_pkg;

    localparam logic [2:0] MIRROR_HORIZ    = 3'd0;
    localparam logic [2:0] MIRROR_VERT     = 3'd1;
    localparam logic [2:0] MIRROR_SINGLE_A = 3'd2;
    localparam logic [2:0] MIRROR_SINGLE_B = 3'd3;
    localparam logic [2:0] MIRROR_FOUR     = 3'd4;

    localparam logic [5:0] PPU_PAL_BASE = 6'h3F;

    typedef enum logic [1:0] {RGN_PT, RGN_NT, RGN_PAL} region_e;

    typedef struct packed {
        logic        wr;
        logic [13:0] addr;
        logic [7:0]  wdata;
        logic        cpu;
    } vram_req_t;

    function automatic region_e decode_rgn(input logic [13:0] addr);
        if (!addr[13]) return RGN_PT;
        if (addr[13:8] == PPU_PAL_BASE) return RGN_PAL;
        return RGN_NT;
    endfunction

    // 3F10/14/18/1C fold onto the backdrop entries 3F00/04/08/0C.
    function automatic logic [4:0] pal_idx(input logic [4:0] addr);
        return {addr[4] & (addr[1:0] != 2'b00), addr[3:0]};
    endfunction

    function automatic logic [11:0] nt_map(input logic [2:0] mode, input logic [11:0] addr,
                                           input logic four_ok);
        case (mode)
            MIRROR_VERT:     return {1'b0, addr[10], addr[9:0]};
            MIRROR_SINGLE_A: return {2'b00, addr[9:0]};
            MIRROR_SINGLE_B: return {2'b01, addr[9:0]};
            MIRROR_FOUR:     return four_ok ? addr : {1'b0, addr[10], addr[9:0]};
            default:         return {1'b0, addr[11], addr[9:0]};
        endcase
    endfunction

endpackage

// File: rtl/ppu_vram_arb.sv
// Renderer-priority arbiter with a starvation counter that eventually forces a CPU grant.
module ppu_vram_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rnd_req,
    input  logic cpu_req,
    output logic rnd_gnt,
    output logic cpu_gnt
);

    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt == 4'(STARVE_MAX));
    // Grants are masked during reset so nothing is acked or written while held.
    assign cpu_gnt = rst_n && cpu_req && (!rnd_req || starved);
    assign rnd_gnt = rst_n && rnd_req && !cpu_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  starve_cnt <= '0;
        else if (!cpu_req || cpu_gnt) starve_cnt <= '0;
        else if (!starved)           starve_cnt <= starve_cnt + 4'd1;
    end

endmodule

// File: rtl/single_port_ram_sync.sv
// Synchronous single-port RAM, read-before-write, contents not reset.
module single_port_ram_sync #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ppu_vram_ctrl.sv
// PPU VRAM controller: arbitrates renderer/CPU onto pattern, name-table and palette storage.
module ppu_vram_ctrl
    import ppu_pkg::*;
#(
    parameter int NT_ADDR_W   = 11,
    parameter bit PT_WRITABLE = 1'b1,
    parameter int STARVE_MAX  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  mirror_mode,
    input  logic        rnd_req,
    input  logic [13:0] rnd_addr,
    output logic        rnd_ack,
    output logic        rnd_rvalid,
    output logic [7:0]  rnd_rdata,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [13:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic        cpu_rvalid,
    output logic [7:0]  cpu_rdata
);

    logic                 rnd_gnt, cpu_gnt, gnt;
    vram_req_t            req;
    region_e              rgn, rd_rgn;
    logic [4:0]           pidx;
    logic [NT_ADDR_W-1:0] nt_addr;
    logic [7:0]           pt_rdata, nt_rdata, rd_data, rnd_hold, cpu_hold;
    logic [5:0]           pal [32];
    logic [5:0]           pal_q;
    logic                 rd_vld, rd_cpu;

    ppu_vram_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .rnd_req (rnd_req),
        .cpu_req (cpu_req),
        .rnd_gnt (rnd_gnt),
        .cpu_gnt (cpu_gnt)
    );

    assign gnt     = rnd_gnt | cpu_gnt;
    assign rnd_ack = rnd_gnt;
    assign cpu_ack = cpu_gnt;

    always_comb begin
        if (cpu_gnt) req = '{wr: cpu_wr, addr: cpu_addr, wdata: cpu_wdata, cpu: 1'b1};
        else         req = '{wr: 1'b0, addr: rnd_addr, wdata: 8'h00, cpu: 1'b0};
    end

    assign rgn     = decode_rgn(req.addr);
    assign pidx    = pal_idx(req.addr[4:0]);
    assign nt_addr = NT_ADDR_W'(nt_map(mirror_mode, req.addr[11:0], NT_ADDR_W >= 12));

    single_port_ram_sync #(.ADDR_W(13), .DATA_W(8)) u_pt_ram (
        .clk   (clk),
        .en    (gnt && rgn == RGN_PT),
        .we    (gnt && rgn == RGN_PT && req.wr && PT_WRITABLE),
        .addr  (req.addr[12:0]),
        .wdata (req.wdata),
        .rdata (pt_rdata)
    );

    single_port_ram_sync #(.ADDR_W(NT_ADDR_W), .DATA_W(8)) u_nt_ram (
        .clk   (clk),
        .en    (gnt && rgn == RGN_NT),
        .we    (gnt && rgn == RGN_NT && req.wr),
        .addr  (nt_addr),
        .wdata (req.wdata),
        .rdata (nt_rdata)
    );

    // Read tag: palette data is captured here so every region shares the BRAM latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= 1'b0;
            rd_cpu <= 1'b0;
            rd_rgn <= RGN_PT;
            pal_q  <= '0;
            for (int i = 0; i < 32; i++) pal[i] <= '0;
        end else begin
            rd_vld <= gnt && !req.wr;
            rd_cpu <= req.cpu;
            rd_rgn <= rgn;
            if (gnt && rgn == RGN_PAL) begin
                if (req.wr) pal[pidx] <= req.wdata[5:0];
                else        pal_q     <= pal[pidx];
            end
        end
    end

    always_comb begin
        case (rd_rgn)
            RGN_PT:  rd_data = pt_rdata;
            RGN_NT:  rd_data = nt_rdata;
            default: rd_data = {2'b00, pal_q};
        endcase
    end

    assign rnd_rvalid = rd_vld & ~rd_cpu;
    assign cpu_rvalid = rd_vld & rd_cpu;
    assign rnd_rdata  = rnd_rvalid ? rd_data : rnd_hold;
    assign cpu_rdata  = cpu_rvalid ? rd_data : cpu_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_hold <= '0;
            cpu_hold <= '0;
        end else begin
            if (rnd_rvalid) rnd_hold <= rd_data;
            if (cpu_rvalid) cpu_hold <= rd_data;
        end
    end

endmodule

// File: tb/tb_ppu_vram_ctrl.sv
// Scoreboard bench for ppu_vram_ctrl: ack-time model pushes expectations, monitor pops on rvalid.
module tb_ppu_vram_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  mirror_mode = 3'd0;
    logic        rnd_req = 1'b0, cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [13:0] rnd_addr = '0, cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        rnd_ack, rnd_rvalid, cpu_ack, cpu_rvalid;
    logic [7:0]  rnd_rdata, cpu_rdata;

    logic [2:0]  r_mode = 3'd0;
    logic        r_rnd_req = 1'b0, r_cpu_req = 1'b0, r_cpu_wr = 1'b0;
    logic [13:0] r_rnd_addr = '0, r_cpu_addr = '0;
    logic [7:0]  r_cpu_wdata = '0;
    logic        r_rnd_ack, r_rnd_rvalid, r_cpu_ack, r_cpu_rvalid;
    logic [7:0]  r_rnd_rdata, r_cpu_rdata;

    ppu_vram_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .mirror_mode(mirror_mode),
        .rnd_req(rnd_req), .rnd_addr(rnd_addr), .rnd_ack(rnd_ack),
        .rnd_rvalid(rnd_rvalid), .rnd_rdata(rnd_rdata),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata)
    );

    ppu_vram_ctrl #(.NT_ADDR_W(11), .PT_WRITABLE(1'b0), .STARVE_MAX(4)) u_rom (
        .clk(clk), .rst_n(rst_n), .mirror_mode(r_mode),
        .rnd_req(r_rnd_req), .rnd_addr(r_rnd_addr), .rnd_ack(r_rnd_ack),
        .rnd_rvalid(r_rnd_rvalid), .rnd_rdata(r_rnd_rdata),
        .cpu_req(r_cpu_req), .cpu_wr(r_cpu_wr), .cpu_addr(r_cpu_addr), .cpu_wdata(r_cpu_wdata),
        .cpu_ack(r_cpu_ack), .cpu_rvalid(r_cpu_rvalid), .cpu_rdata(r_cpu_rdata)
    );

    int vectors = 0, miscompares = 0, cyc = 0;

    typedef struct {bit known; int val; int due;} exp_t;
    exp_t rq[$], cq[$];
    int pt_m[int], nt_m[int];
    int pal_m[32];

    task automatic chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: region, mirroring and palette folding from plain address arithmetic.
    function automatic int region(int addr);
        if (addr < 'h2000) return 0;
        if ((addr >> 8) == 'h3F) return 2;
        return 1;
    endfunction

    function automatic int phys_nt(int mode, int addr);
        int q, scr;
        q = (addr >> 10) & 3;
        case (mode)
            1, 4:    scr = q & 1;   // four-screen falls back to vertical with a 2 KB table
            2:       scr = 0;
            3:       scr = 1;
            default: scr = q >> 1;
        endcase
        return scr * 1024 + (addr & 1023);
    endfunction

    function automatic int pal_i(int addr);
        int i;
        i = addr & 31;
        if ((i & 3) == 0) i = i & 15;
        return i;
    endfunction

    task automatic model_rd(int addr, int mode, output bit k, output int v);
        int p;
        k = 1'b1;
        v = 0;
        case (region(addr))
            0: begin k = pt_m.exists(addr); if (k) v = pt_m[addr]; end
            1: begin p = phys_nt(mode, addr); k = nt_m.exists(p); if (k) v = nt_m[p]; end
            default: v = pal_m[pal_i(addr)];
        endcase
    endtask

    task automatic model_wr(int addr, int mode, int d);
        case (region(addr))
            0:       pt_m[addr] = d;
            1:       nt_m[phys_nt(mode, addr)] = d;
            default: pal_m[pal_i(addr)] = d & 63;
        endcase
    endtask

    task automatic mon_port(string nm, logic v, logic [7:0] d, bit is_cpu);
        exp_t e;
        bit have;
        have = is_cpu ? (cq.size() > 0) : (rq.size() > 0);
        if (have) e = is_cpu ? cq[0] : rq[0];
        if (v) begin
            if (!have) chk({nm, "_spurious_rvalid"}, 1, 0);
            else begin
                if (is_cpu) void'(cq.pop_front()); else void'(rq.pop_front());
                chk({nm, "_latency"}, cyc, e.due);
                if (e.known) chk({nm, "_rdata"}, int'(d), e.val);
            end
        end else if (have && e.due <= cyc) begin
            if (is_cpu) void'(cq.pop_front()); else void'(rq.pop_front());
            chk({nm, "_missing_rvalid"}, 0, 1);
        end
    endtask

    initial forever begin
        bit k;
        int v;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            rq.delete();
            cq.delete();
            for (int i = 0; i < 32; i++) pal_m[i] = 0;
        end else begin
            mon_port("rnd", rnd_rvalid, rnd_rdata, 1'b0);
            mon_port("cpu", cpu_rvalid, cpu_rdata, 1'b1);
            if (rnd_ack || cpu_ack) chk("single_grant", int'(rnd_ack & cpu_ack), 0);
            if (rnd_ack) begin
                model_rd(int'(rnd_addr), int'(mirror_mode), k, v);
                rq.push_back('{k, v, cyc + 1});
            end
            if (cpu_ack) begin
                if (cpu_wr) model_wr(int'(cpu_addr), int'(mirror_mode), int'(cpu_wdata));
                else begin
                    model_rd(int'(cpu_addr), int'(mirror_mode), k, v);
                    cq.push_back('{k, v, cyc + 1});
                end
            end
        end
    end

    // Drivers start and end at posedge+1; the request is held until the ack is seen.
    task automatic cpu_op(bit wr, int addr, int d, output int waits);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = 14'(addr); cpu_wdata = 8'(d);
        waits = 0;
        do begin @(negedge clk); waits++; end while (!cpu_ack && waits < 200);
        if (!cpu_ack) chk("cpu_ack_timeout", 0, 1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic rnd_rd(int addr, output int waits);
        rnd_req = 1'b1; rnd_addr = 14'(addr);
        waits = 0;
        do begin @(negedge clk); waits++; end while (!rnd_ack && waits < 200);
        if (!rnd_ack) chk("rnd_ack_timeout", 0, 1);
        @(posedge clk); #1;
        rnd_req = 1'b0;
    endtask

    task automatic rom_op(bit wr, int addr, int d, output int rd);
        int n;
        r_cpu_req = 1'b1; r_cpu_wr = wr; r_cpu_addr = 14'(addr); r_cpu_wdata = 8'(d);
        n = 0;
        rd = 0;
        do begin @(negedge clk); n++; end while (!r_cpu_ack && n < 50);
        chk("rom_ack", int'(r_cpu_ack), 1);
        @(posedge clk); #1;
        r_cpu_req = 1'b0;
        if (!wr) begin
            @(negedge clk);
            chk("rom_rvalid", int'(r_cpu_rvalid), 1);
            rd = int'(r_cpu_rdata);
            @(posedge clk); #1;
        end
    endtask

    function automatic int rand_addr();
        case ($urandom_range(0, 2))
            0:       return $urandom_range(0, 15);
            1:       return 'h2000 | ($urandom_range(0, 1) << 12) | ($urandom_range(0, 2) << 10)
                            | $urandom_range(0, 7);
            default: return 'h3F00 | $urandom_range(0, 63);
        endcase
    endfunction

    initial begin
        int w, cw, prior, after;
        int rw[8];

        rnd_req = 1'b1; cpu_req = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_rnd_ack", int'(rnd_ack), 0);
        chk("rst_cpu_ack", int'(cpu_ack), 0);
        chk("rst_rnd_rvalid", int'(rnd_rvalid), 0);
        chk("rst_cpu_rvalid", int'(cpu_rvalid), 0);
        chk("rst_rnd_rdata", int'(rnd_rdata), 0);
        chk("rst_cpu_rdata", int'(cpu_rdata), 0);
        rnd_req = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        mirror_mode = 3'd1;
        cpu_op(1, 'h2005, 'hA5, w);
        cpu_op(0, 'h2805, 0, w);
        cpu_op(1, 'h2405, 'h00, w);
        mirror_mode = 3'd0;
        cpu_op(1, 'h2005, 'hA5, w);
        cpu_op(0, 'h2405, 0, w);

        cpu_op(1, 'h3F10, 'h3F, w);
        cpu_op(0, 'h3F00, 0, w);
        cpu_op(1, 'h3F01, 'hFF, w);
        cpu_op(0, 'h3F01, 0, w);

        fork
            for (int i = 0; i < 8; i++) rnd_rd('h3F00 + i, rw[i]);
            cpu_op(0, 'h3F00, 0, cw);
        join
        chk("starve_cpu_wait", cw, 5);
        chk("rnd_resume_wait", rw[4], 2);

        cpu_op(1, 'h0000, 'h11, w);
        cpu_op(1, 'h2000, 'h22, w);
        rnd_rd('h0000, rw[0]);
        rnd_rd('h2000, rw[1]);
        rnd_rd('h3F00, rw[2]);
        for (int i = 0; i < 3; i++) chk("b2b_ack_wait", rw[i], 1);

        mirror_mode = 3'd4;
        cpu_op(1, 'h2807, 'h55, w);
        mirror_mode = 3'd1;
        cpu_op(0, 'h2007, 0, w);

        rom_op(0, 'h0100, 0, prior);
        rom_op(1, 'h0100, 'h12, after);
        rom_op(0, 'h0100, 0, after);
        chk("rom_pt_unchanged", after, prior);
        r_mode = 3'd4;
        rom_op(1, 'h2805, 'h3C, after);
        r_mode = 3'd1;
        rom_op(0, 'h2005, 0, after);
        chk("rom_four_as_vert", after, 'h3C);

        cpu_op(1, 'h3F05, 'h2A, w);
        cpu_op(0, 'h3F05, 0, w);
        rst_n = 1'b0;
        rnd_req = 1'b1; cpu_req = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_cpu_rvalid", int'(cpu_rvalid), 0);
            chk("rstmid_rnd_rvalid", int'(rnd_rvalid), 0);
            chk("rstmid_acks", int'(rnd_ack | cpu_ack), 0);
            chk("rstmid_rdata", int'(cpu_rdata | rnd_rdata), 0);
        end
        rnd_req = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        cpu_op(0, 'h3F05, 0, w);
        rnd_rd('h3F10, w);

        fork
            for (int i = 0; i < 150; i++) begin
                rnd_rd(rand_addr(), w);
                if ($urandom_range(0, 3) == 0) begin repeat ($urandom_range(1, 2)) @(posedge clk); #1; end
            end
            for (int i = 0; i < 150; i++) begin
                if ($urandom_range(0, 7) == 0) mirror_mode = 3'($urandom_range(0, 4));
                cpu_op(1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 255), w);
            end
        join
        repeat (3) @(posedge clk);
        #1;
        chk("queues_drained", rq.size() + cq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
